// File: rtl/player_move_ctrl_pkg.sv
// Shared game parameters: map size, start tile, handshake timing and direction codes.
package player_move_ctrl_pkg;

    localparam int DEF_MAP_WIDTH       = 13;
    localparam int DEF_MAP_HEIGHT      = 13;
    localparam int DEF_START_X         = 6;
    localparam int DEF_START_Y         = 12;
    localparam int DEF_ACK_TIMEOUT     = 15;
    localparam int DEF_COOLDOWN_CYCLES = 4;
    localparam int CNT_W               = 8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    // Button bit order is {right,left,down,up}; lower bits win.
    function automatic dir_e pick_dir(input logic [3:0] rise);
        if (rise[0])      return DIR_UP;
        else if (rise[1]) return DIR_DOWN;
        else if (rise[2]) return DIR_LEFT;
        else              return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Move request / commit handshake between the player controller and the map-interaction stage.
interface player_move_ctrl_if;

    logic       player_ask_move;
    logic [3:0] player_ask_x;
    logic [3:0] player_ask_y;
    logic       accept_move;
    logic [3:0] goto_x;
    logic [3:0] goto_y;
    logic [3:0] key_num_in;

    modport master (
        output player_ask_move, player_ask_x, player_ask_y,
        input  accept_move, goto_x, goto_y, key_num_in
    );

    modport slave (
        input  player_ask_move, player_ask_x, player_ask_y,
        output accept_move, goto_x, goto_y, key_num_in
    );

endinterface

// File: rtl/player_move_ctrl_btn_edge_sync.sv
// Two-flop synchronizer per button bit followed by a one-cycle rising-edge pulse.
module btn_edge_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/player_move_ctrl.sv
// Player move controller: one move request per button press, commits position/keys on accept.
//   state    | meaning
//   IDLE     | waiting for a fresh button edge
//   REQ      | single-cycle ask pulse with latched target
//   WAIT     | waiting for accept_move, bounded by ACK_TIMEOUT
//   COOLDOWN | dead time after commit or abandon
module player_move_ctrl
    import player_move_ctrl_pkg::*;
#(
    parameter int MAP_WIDTH       = DEF_MAP_WIDTH,
    parameter int MAP_HEIGHT      = DEF_MAP_HEIGHT,
    parameter int START_X         = DEF_START_X,
    parameter int START_Y         = DEF_START_Y,
    parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [3:0]         btn,
    player_move_ctrl_if.master mv,
    output logic [3:0]         player_x,
    output logic [3:0]         player_y,
    output logic [3:0]         key_num,
    output logic [1:0]         player_dir,
    output logic               busy
);

    localparam logic [3:0]       X_MAX     = 4'(MAP_WIDTH - 1);
    localparam logic [3:0]       Y_MAX     = 4'(MAP_HEIGHT - 1);
    localparam logic [3:0]       X_RST     = 4'(START_X);
    localparam logic [3:0]       Y_RST     = 4'(START_Y);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [3:0] btn_rise;

    btn_edge_sync #(.WIDTH(4)) u_btn_edge_sync (
        .clk  (clk),
        .rstn (rstn),
        .din  (btn),
        .rise (btn_rise)
    );

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [3:0]       x_q, x_d, y_q, y_d, key_q, key_d;
    logic [3:0]       ask_x_q, ask_x_d, ask_y_q, ask_y_d;
    logic             ask_q, ask_d, busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    dir_e       sel_dir;
    logic       blocked;
    logic [3:0] tgt_x, tgt_y;

    // Edge checks precede the +/-1 so an off-map target is never requested.
    always_comb begin
        sel_dir = pick_dir(btn_rise);
        tgt_x   = x_q;
        tgt_y   = y_q;
        blocked = 1'b0;
        case (sel_dir)
            DIR_UP: begin
                blocked = (y_q == 4'd0);
                tgt_y   = y_q - 4'd1;
            end
            DIR_DOWN: begin
                blocked = (y_q == Y_MAX);
                tgt_y   = y_q + 4'd1;
            end
            DIR_LEFT: begin
                blocked = (x_q == 4'd0);
                tgt_x   = x_q - 4'd1;
            end
            default: begin
                blocked = (x_q == X_MAX);
                tgt_x   = x_q + 4'd1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        key_d   = key_q;
        ask_x_d = ask_x_q;
        ask_y_d = ask_y_q;
        ask_d   = 1'b0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|btn_rise) begin
                    dir_d = sel_dir;
                    if (!blocked) begin
                        ask_x_d = tgt_x;
                        ask_y_d = tgt_y;
                        ask_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mv.accept_move) begin
                    x_d     = mv.goto_x;
                    y_d     = mv.goto_y;
                    key_d   = mv.key_num_in;
                    cnt_d   = COOL_LOAD;
                    state_d = ST_COOLDOWN;
                end else if (cnt_q == ACK_LAST) begin
                    cnt_d   = COOL_LOAD;
                    state_d = ST_COOLDOWN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            key_q   <= 4'd0;
            ask_x_q <= X_RST;
            ask_y_q <= Y_RST;
            ask_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            key_q   <= key_d;
            ask_x_q <= ask_x_d;
            ask_y_q <= ask_y_d;
            ask_q   <= ask_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mv.player_ask_move = ask_q;
    assign mv.player_ask_x    = ask_x_q;
    assign mv.player_ask_y    = ask_y_q;
    assign player_x           = x_q;
    assign player_y           = y_q;
    assign key_num            = key_q;
    assign player_dir         = dir_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: moves, blocked moves, map edges, timeout, arbitration, reset.
module tb_player_move_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] btn;
    logic [3:0] player_x, player_y, key_num;
    logic [1:0] player_dir;
    logic       busy;

    int errors = 0;
    int checks = 0;

    player_move_ctrl_if mv_if ();

    player_move_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn        (btn),
        .mv         (mv_if),
        .player_x   (player_x),
        .player_y   (player_y),
        .key_num    (key_num),
        .player_dir (player_dir),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          first_ask, n_ask;
    logic [3:0]  ax, ay;
    logic [63:0] busy_tr;

    // Press at negedge 0; sample outputs at each following negedge, then drive that negedge's inputs.
    task automatic run_move(input logic [3:0] bits, input logic [3:0] bits2, input int k2,
                            input int acc_at, input logic [3:0] gx, input logic [3:0] gy,
                            input logic [3:0] kin, input int window,
                            output int fa, output int na, output logic [3:0] rx,
                            output logic [3:0] ry, output logic [63:0] btr);
        btn = 4'b0;
        mv_if.accept_move = 1'b0;
        repeat (3) @(negedge clk);
        btn = bits;
        fa = -1; na = 0; rx = 4'd0; ry = 4'd0; btr = '0;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            btr[k] = busy;
            if (mv_if.player_ask_move) begin
                na++;
                if (fa < 0) begin
                    fa = k;
                    rx = mv_if.player_ask_x;
                    ry = mv_if.player_ask_y;
                end
            end
            if (k == k2) btn = bits | bits2;
            mv_if.accept_move = (k == acc_at);
            if (k == acc_at) begin
                mv_if.goto_x     = gx;
                mv_if.goto_y     = gy;
                mv_if.key_num_in = kin;
            end
        end
        mv_if.accept_move = 1'b0;
        btn = 4'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        btn = 4'b0;
        mv_if.accept_move = 1'b0;
        mv_if.goto_x = 4'd0;
        mv_if.goto_y = 4'd0;
        mv_if.key_num_in = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (player_x !== 4'd6) begin errors++; $display("FAIL reset_x: got %0d want 6", player_x); end
        checks++; if (player_y !== 4'd12) begin errors++; $display("FAIL reset_y: got %0d want 12", player_y); end
        checks++; if (key_num !== 4'd0) begin errors++; $display("FAIL reset_key: got %0d want 0", key_num); end
        checks++; if (player_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d want 0", player_dir); end
        checks++; if (mv_if.player_ask_move !== 1'b0) begin errors++; $display("FAIL reset_ask: got %0b want 0", mv_if.player_ask_move); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (mv_if.player_ask_x !== 4'd6 || mv_if.player_ask_y !== 4'd12) begin
            errors++; $display("FAIL reset_ask_xy: got (%0d,%0d) want (6,12)", mv_if.player_ask_x, mv_if.player_ask_y);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_right_move;
        run_move(4'b1000, 4'b0, 0, 6, 4'd7, 4'd12, 4'd1, 14, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (first_ask !== 3) begin errors++; $display("FAIL right_latency: got %0d want 3", first_ask); end
        checks++; if (n_ask !== 1) begin errors++; $display("FAIL right_ask_count: got %0d want 1", n_ask); end
        checks++; if (ax !== 4'd7 || ay !== 4'd12) begin errors++; $display("FAIL right_ask_xy: got (%0d,%0d) want (7,12)", ax, ay); end
        checks++; if (player_x !== 4'd7 || player_y !== 4'd12) begin errors++; $display("FAIL right_pos: got (%0d,%0d) want (7,12)", player_x, player_y); end
        checks++; if (key_num !== 4'd1) begin errors++; $display("FAIL right_key: got %0d want 1", key_num); end
        checks++; if (player_dir !== 2'd3) begin errors++; $display("FAIL right_dir: got %0d want 3", player_dir); end
        checks++; if (busy_tr[2] !== 1'b0 || busy_tr[3] !== 1'b1) begin errors++; $display("FAIL right_busy_start: got %0b%0b want 01", busy_tr[2], busy_tr[3]); end
        checks++; if (busy_tr[10] !== 1'b1 || busy_tr[11] !== 1'b0) begin errors++; $display("FAIL right_busy_end: got %0b%0b want 10", busy_tr[10], busy_tr[11]); end
    endtask

    task automatic test_blocked;
        run_move(4'b0001, 4'b0, 0, 6, 4'd7, 4'd12, 4'd1, 14, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (n_ask !== 1) begin errors++; $display("FAIL blocked_ask_count: got %0d want 1", n_ask); end
        checks++; if (ax !== 4'd7 || ay !== 4'd11) begin errors++; $display("FAIL blocked_ask_xy: got (%0d,%0d) want (7,11)", ax, ay); end
        checks++; if (player_x !== 4'd7 || player_y !== 4'd12) begin errors++; $display("FAIL blocked_pos: got (%0d,%0d) want (7,12)", player_x, player_y); end
        checks++; if (player_dir !== 2'd0) begin errors++; $display("FAIL blocked_dir: got %0d want 0", player_dir); end
    endtask

    task automatic test_map_edge;
        run_move(4'b0001, 4'b0, 0, 6, 4'd0, 4'd12, 4'd1, 14, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (player_x !== 4'd0 || player_dir !== 2'd0) begin errors++; $display("FAIL edge_setup: got x=%0d dir=%0d want x=0 dir=0", player_x, player_dir); end
        run_move(4'b0100, 4'b0, 0, 0, 4'd0, 4'd0, 4'd0, 10, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (n_ask !== 0) begin errors++; $display("FAIL edge_left_ask: got %0d want 0", n_ask); end
        checks++; if (player_dir !== 2'd2) begin errors++; $display("FAIL edge_left_dir: got %0d want 2", player_dir); end
        checks++; if (busy_tr !== 64'd0) begin errors++; $display("FAIL edge_left_busy: got %h want 0", busy_tr); end
        run_move(4'b0010, 4'b0, 0, 0, 4'd0, 4'd0, 4'd0, 10, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (n_ask !== 0 || player_dir !== 2'd1) begin errors++; $display("FAIL edge_down: got asks=%0d dir=%0d want 0,1", n_ask, player_dir); end
        run_move(4'b0001, 4'b0, 0, 6, 4'd12, 4'd12, 4'd1, 14, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (ax !== 4'd0 || ay !== 4'd11 || player_x !== 4'd12) begin
            errors++; $display("FAIL edge_setup2: got ask (%0d,%0d) x=%0d want (0,11) x=12", ax, ay, player_x);
        end
        run_move(4'b1000, 4'b0, 0, 0, 4'd0, 4'd0, 4'd0, 10, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (n_ask !== 0 || player_dir !== 2'd3 || player_x !== 4'd12) begin
            errors++; $display("FAIL edge_right: got asks=%0d dir=%0d x=%0d want 0,3,12", n_ask, player_dir, player_x);
        end
    endtask

    task automatic test_timeout;
        run_move(4'b0001, 4'b0, 0, 6, 4'd6, 4'd5, 4'd2, 14, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (player_x !== 4'd6 || player_y !== 4'd5 || key_num !== 4'd2) begin
            errors++; $display("FAIL timeout_setup: got (%0d,%0d) k=%0d want (6,5) k=2", player_x, player_y, key_num);
        end
        run_move(4'b0010, 4'b0, 0, 20, 4'd9, 4'd9, 4'd9, 26, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (n_ask !== 1 || ax !== 4'd6 || ay !== 4'd6) begin
            errors++; $display("FAIL timeout_ask: got n=%0d (%0d,%0d) want n=1 (6,6)", n_ask, ax, ay);
        end
        checks++; if (busy_tr[18] !== 1'b1 || busy_tr[22] !== 1'b1 || busy_tr[23] !== 1'b0) begin
            errors++; $display("FAIL timeout_busy: got %0b%0b%0b want 110", busy_tr[18], busy_tr[22], busy_tr[23]);
        end
        checks++; if (player_x !== 4'd6 || player_y !== 4'd5 || key_num !== 4'd2) begin
            errors++; $display("FAIL timeout_no_commit: got (%0d,%0d) k=%0d want (6,5) k=2", player_x, player_y, key_num);
        end
        checks++; if (player_dir !== 2'd1) begin errors++; $display("FAIL timeout_dir: got %0d want 1", player_dir); end
    endtask

    task automatic test_concurrency;
        run_move(4'b1001, 4'b0, 0, 6, 4'd6, 4'd4, 4'd3, 14, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (n_ask !== 1 || ax !== 4'd6 || ay !== 4'd4) begin
            errors++; $display("FAIL arb_ask: got n=%0d (%0d,%0d) want n=1 (6,4)", n_ask, ax, ay);
        end
        checks++; if (player_dir !== 2'd0 || player_y !== 4'd4 || key_num !== 4'd3) begin
            errors++; $display("FAIL arb_commit: got dir=%0d y=%0d k=%0d want 0,4,3", player_dir, player_y, key_num);
        end
        run_move(4'b0001, 4'b0100, 4, 6, 4'd6, 4'd3, 4'd3, 20, first_ask, n_ask, ax, ay, busy_tr);
        checks++; if (n_ask !== 1 || ay !== 4'd3) begin errors++; $display("FAIL wait_press_ask: got n=%0d y=%0d want n=1 y=3", n_ask, ay); end
        checks++; if (player_dir !== 2'd0 || player_y !== 4'd3) begin
            errors++; $display("FAIL wait_press_state: got dir=%0d y=%0d want 0,3", player_dir, player_y);
        end
    endtask

    task automatic test_reset_mid_wait;
        btn = 4'b0;
        repeat (3) @(negedge clk);
        btn = 4'b1000;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %0b want 1", busy); end
        rstn = 1'b0;
        btn = 4'b0;
        mv_if.goto_x = 4'd9;
        mv_if.goto_y = 4'd9;
        mv_if.key_num_in = 4'd7;
        mv_if.accept_move = 1'b1;
        #1;
        checks++; if (player_x !== 4'd6 || player_y !== 4'd12 || key_num !== 4'd0) begin
            errors++; $display("FAIL rst_async_pos: got (%0d,%0d) k=%0d want (6,12) k=0", player_x, player_y, key_num);
        end
        checks++; if (busy !== 1'b0 || player_dir !== 2'd0 || mv_if.player_ask_move !== 1'b0) begin
            errors++; $display("FAIL rst_async_ctrl: got busy=%0b dir=%0d ask=%0b want 0,0,0", busy, player_dir, mv_if.player_ask_move);
        end
        @(negedge clk);
        rstn = 1'b1;
        mv_if.accept_move = 1'b0;
        n_ask = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mv_if.player_ask_move) n_ask++;
        end
        checks++; if (n_ask !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_after_idle: got asks=%0d busy=%0b want 0,0", n_ask, busy); end
        checks++; if (player_x !== 4'd6 || player_y !== 4'd12 || key_num !== 4'd0) begin
            errors++; $display("FAIL rst_after_pos: got (%0d,%0d) k=%0d want (6,12) k=0", player_x, player_y, key_num);
        end
    endtask

    initial begin
        test_reset();
        test_right_move();
        test_blocked();
        test_map_edge();
        test_timeout();
        test_concurrency();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
